// File: rtl/osd_pkg.sv
// OSD SPI command-channel shared definitions: opcodes, command bytes, geometry, FSM states.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package osd_pkg;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    localparam logic [7:0] CMD_DISABLE = 8'h40;
    localparam logic [7:0] CMD_ENABLE  = 8'h41;
    localparam logic [7:0] CMD_WRITE   = 8'h20;

    localparam int OSD_LINES      = 8;
    localparam int OSD_LINE_BYTES = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_FETCH,
        S_HOLD,
        S_GAP
    } state_t;

    // First byte on the wire for a given opcode; line index only matters for writes.
    function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [2:0] line);
        logic [7:0] b;
        case (op)
            OP_DISABLE: b = CMD_DISABLE;
            OP_ENABLE:  b = CMD_ENABLE;
            default:    b = CMD_WRITE | {5'd0, line};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/osd_spi_tick.sv
// Half-period divider for the OSD SPI master: pulses o_tick once every CLK_DIV clocks.
// Latency: first tick CLK_DIV cycles after a clear; then one tick per CLK_DIV cycles.
// Backpressure: none; the owner holds i_clr to freeze the phase (idle, clock stretch).
// Ports: i_clk, i_reset (sync, active high), i_clr (sync reload), o_tick (counter at zero).
module osd_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    // Counts RELOAD..0; the zero cycle is the tick and also reloads.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr || (r_cnt == 8'd0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/osd_spi_master.sv
// OSD SPI transmitter: turns enable/disable/write-line commands into mode-0 SPI frames.
// Latency: ss falls on the accept edge; done pulses (2+16*(1+N)+2)*CLK_DIV + N clk later.
// Backpressure: cmd_ready only in IDLE; payload fetch stretches sck low until dat_valid.
// Ports: i_clk, i_reset; cmd i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_line;
//        payload i_dat_valid/o_dat_ready/i_dat_byte; status o_busy/o_done; SPI o_sck/o_ss/o_sdi.
module osd_spi_master
    import osd_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [2:0] i_cmd_line,
    input  logic       i_dat_valid,
    output logic       o_dat_ready,
    input  logic [7:0] i_dat_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_sck,
    output logic       o_ss,
    output logic       o_sdi
);

    state_t     r_state;
    logic       r_sck;
    logic       r_ss;
    logic       r_done;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic [7:0] r_byte_cnt;
    logic       r_pay;

    state_t     w_state_nxt;
    logic       w_sck_nxt;
    logic       w_ss_nxt;
    logic       w_done_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_bit_nxt;
    logic [7:0] w_byte_cnt_nxt;
    logic       w_pay_nxt;
    logic       w_tick;
    logic       w_tick_clr;
    logic       w_accept;

    osd_spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    assign o_cmd_ready = (r_state == S_IDLE) && !i_reset;
    assign o_dat_ready = (r_state == S_FETCH);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_sck       = r_sck;
    assign o_ss        = r_ss;
    assign o_sdi       = r_shift[7];
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_done     <= 1'b0;
            r_shift    <= 8'd0;
            r_bit      <= 3'd0;
            r_byte_cnt <= 8'd0;
            r_pay      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sck      <= w_sck_nxt;
            r_ss       <= w_ss_nxt;
            r_done     <= w_done_nxt;
            r_shift    <= w_shift_nxt;
            r_bit      <= w_bit_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_pay      <= w_pay_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sck_nxt      = r_sck;
        w_ss_nxt       = r_ss;
        w_done_nxt     = 1'b0;
        w_shift_nxt    = r_shift;
        w_bit_nxt      = r_bit;
        w_byte_cnt_nxt = r_byte_cnt;
        w_pay_nxt      = r_pay;
        w_tick_clr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Divider held so the first half-period after accept is full length.
                w_tick_clr = 1'b1;
                if (w_accept) begin
                    if (i_cmd_op == OP_RSVD) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_SETUP;
                        w_ss_nxt       = 1'b0;
                        w_shift_nxt    = cmd_byte(i_cmd_op, i_cmd_line);
                        w_bit_nxt      = 3'd7;
                        w_byte_cnt_nxt = 8'd0;
                        w_pay_nxt      = (i_cmd_op == OP_WRITE);
                    end
                end
            end
            S_SETUP: begin
                // Select lead time is a full low sck period (setup half + one LOW half)
                // so the command byte has the same 16-half-period shape as payload bytes.
                if (w_tick) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (w_tick) begin
                    w_sck_nxt   = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_tick) begin
                    w_sck_nxt = 1'b0;
                    if (r_bit != 3'd0) begin
                        // Data moves on the falling edge, a half-period ahead of the next rise.
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_bit_nxt   = r_bit - 3'd1;
                        w_state_nxt = S_LOW;
                    end else if (r_pay) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_FETCH: begin
                // sck stays low for as long as the source stalls; divider restarts on handshake.
                w_tick_clr = 1'b1;
                if (i_dat_valid) begin
                    w_shift_nxt    = i_dat_byte;
                    w_bit_nxt      = 3'd7;
                    w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                    if (r_byte_cnt == 8'(OSD_LINE_BYTES - 1)) begin
                        w_pay_nxt = 1'b0;
                    end
                    w_state_nxt = S_LOW;
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_ss_nxt    = 1'b1;
                    w_bit_nxt   = 3'd1;  // bit counter reused to time the two gap half-periods
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_bit == 3'd0) begin
                        w_done_nxt  = 1'b1;
                        w_shift_nxt = 8'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_osd_spi_master.sv
// Self-checking bench for osd_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1),
// a receiver model sampling sdi on sck rise, and an expected-frame model built from
// the command-byte table, payload arrays and the frame-length formula.
module tb_osd_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]      rst;
    logic [1:0]      cmd_valid, cmd_ready, dat_valid, dat_ready;
    logic [1:0]      busy, done, sck, ss, sdi;
    logic [1:0][1:0] cmd_op;
    logic [1:0][2:0] cmd_line;
    logic [1:0][7:0] dat_byte;

    osd_spi_master #(.CLK_DIV(4)) dut4 (
        .i_clk(clk), .i_reset(rst[0]), .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]),
        .i_cmd_op(cmd_op[0]), .i_cmd_line(cmd_line[0]), .i_dat_valid(dat_valid[0]),
        .o_dat_ready(dat_ready[0]), .i_dat_byte(dat_byte[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_sck(sck[0]), .o_ss(ss[0]), .o_sdi(sdi[0])
    );

    osd_spi_master #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]),
        .i_cmd_op(cmd_op[1]), .i_cmd_line(cmd_line[1]), .i_dat_valid(dat_valid[1]),
        .o_dat_ready(dat_ready[1]), .i_dat_byte(dat_byte[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_sck(sck[1]), .o_ss(ss[1]), .o_sdi(sdi[1])
    );

    // ---------------- receiver model (one process for both instances) ----------------
    logic [7:0] rx_q0[$];
    logic [7:0] rx_q1[$];
    int         rises[2]    = '{0, 0};
    int         ss_falls[2] = '{0, 0};
    int         sdi_viol[2] = '{0, 0};
    int         last_gap[2] = '{0, 0};
    int         t_rise[2]   = '{0, 0};
    int         bitn[2]     = '{0, 0};
    logic [7:0] shreg[2]    = '{8'd0, 8'd0};
    logic [1:0] p_sck = 2'b00, p_ss = 2'b11, p_sdi = 2'b00;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ss[k]) begin
                bitn[k] = 0;  // select high aborts any partial byte
                if (!p_ss[k]) t_rise[k] = cyc;
            end else begin
                if (p_ss[k]) begin
                    ss_falls[k]++;
                    last_gap[k] = cyc - t_rise[k];
                end
                if (sck[k] && !p_sck[k]) begin
                    rises[k]++;
                    shreg[k] = {shreg[k][6:0], sdi[k]};
                    bitn[k]++;
                    if (bitn[k] == 8) begin
                        bitn[k] = 0;
                        if (k == 0) rx_q0.push_back(shreg[k]);
                        else        rx_q1.push_back(shreg[k]);
                    end
                end
                if ((sdi[k] != p_sdi[k]) && sck[k] && p_sck[k]) sdi_viol[k]++;
            end
        end
        p_sck = sck;
        p_ss  = ss;
        p_sdi = sdi;
    end

    // ---------------- bookkeeping and reference model ----------------
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] pay_mem[256];
    logic [7:0] osd_buf[2048];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_cmd(input int op, input int line);
        if (op == 0) return 8'h40;
        if (op == 1) return 8'h41;
        return 8'(8'h20 + line);
    endfunction

    // Half-periods: setup(2) + 16 per byte + hold/gap(2); one clk per payload fetch plus stalls.
    function automatic int exp_lat(input int div, input int n, input int waits);
        return div * (2 + 16 * (1 + n) + 2) + n + waits;
    endfunction

    function automatic int rx_size(input int k);
        return (k == 0) ? rx_q0.size() : rx_q1.size();
    endfunction

    function automatic int rx_at(input int k, input int i);
        if (i >= rx_size(k)) return -1;
        return (k == 0) ? int'(rx_q0[i]) : int'(rx_q1[i]);
    endfunction

    function automatic int pay_errs(input int k, input int s);
        int e = 0;
        for (int i = 0; i < 256; i++)
            if (rx_at(k, s + 1 + i) != int'(pay_mem[i])) e++;
        return e;
    endfunction

    // Runs one command; returns done latency (edges from accept), handshakes, protocol
    // violations (cmd_ready high or busy low mid-frame), sck-high cycles during the
    // stall, and cycles the DUT waited in fetch for dat_valid.
    task automatic frame(input int k, input int op, input int line, input int stall_idx,
                         input int stall_len, input bit rnd_valid, input int reset_idx,
                         output int lat, output int hs, output int viol,
                         output int stall_sck, output int waits);
        int t_acc = -1;
        int guard = 0;
        int stall_left = stall_len;
        bit fin = 1'b0;
        bit acc_now, hs_now;
        lat = -1; hs = 0; viol = 0; stall_sck = 0; waits = 0;
        @(negedge clk);
        cmd_op[k]    = 2'(op);
        cmd_line[k]  = 3'(line);
        cmd_valid[k] = 1'b1;
        while (!fin && guard < 40000) begin
            guard++;
            dat_byte[k] = pay_mem[hs & 255];
            if (hs == stall_idx && dat_ready[k] && stall_left > 0) begin
                dat_valid[k] = 1'b0;
                stall_left--;
                if (sck[k]) stall_sck++;
            end else if (rnd_valid) begin
                dat_valid[k] = ($urandom_range(0, 3) != 0);
            end else begin
                dat_valid[k] = 1'b1;
            end
            if (dat_ready[k] && !dat_valid[k]) waits++;
            if (t_acc >= 0 && (cmd_ready[k] || !busy[k])) viol++;
            acc_now = cmd_valid[k] && cmd_ready[k];
            hs_now  = dat_valid[k] && dat_ready[k];
            @(posedge clk); #1;
            if (acc_now) begin
                cmd_valid[k] = 1'b0;
                t_acc = cyc;
            end
            if (hs_now) hs++;
            if (done[k]) begin
                fin = 1'b1;
                lat = cyc - t_acc;
            end else if (reset_idx >= 0 && hs == reset_idx) begin
                @(negedge clk);
                rst[k] = 1'b1;
                dat_valid[k] = 1'b0;
                @(posedge clk); #1;
                chk("abort_ss", int'(ss[k]), 1);
                chk("abort_sck", int'(sck[k]), 0);
                chk("abort_busy", int'(busy[k]), 0);
                chk("abort_dat_ready", int'(dat_ready[k]), 0);
                @(negedge clk);
                rst[k] = 1'b0;
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        dat_valid[k] = 1'b0;
        chk("frame_timeout", int'(fin), 1);
    endtask

    initial begin
        int lat, hs, viol, ssk, waits, s, r, f, ln, errs;
        logic [7:0] c;
        rst = 2'b11; cmd_valid = '0; dat_valid = '0; cmd_op = '0; cmd_line = '0; dat_byte = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_ss", int'(ss), 3);
        chk("rst_sck", int'(sck), 0);
        chk("rst_sdi", int'(sdi), 0);
        chk("rst_busy_done", int'({busy, done}), 0);
        chk("rst_dat_ready", int'(dat_ready), 0);
        @(negedge clk);
        rst = 2'b00;
        @(posedge clk); #1;
        chk("idle_cmd_ready", int'(cmd_ready), 3);

        // dat_valid while idle is ignored
        dat_valid[0] = 1'b1;
        @(posedge clk); #1;
        chk("idle_dat_ready", int'(dat_ready[0]), 0);
        dat_valid[0] = 1'b0;

        // Enable, CLK_DIV=4
        s = rx_size(0); r = rises[0];
        frame(0, 1, 0, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("en_latency", lat, exp_lat(4, 0, 0));
        chk("en_nbytes", rx_size(0) - s, 1);
        chk("en_byte", rx_at(0, s), int'(exp_cmd(1, 0)));
        chk("en_rises", rises[0] - r, 8);
        chk("en_ss_end", int'(ss[0]), 1);
        chk("en_busy_ready", viol, 0);
        @(posedge clk); #1;
        chk("en_done_pulse", int'(done[0]), 0);

        // Write line 5, source always valid, payload i^A5
        for (int i = 0; i < 256; i++) pay_mem[i] = 8'(i) ^ 8'hA5;
        s = rx_size(0); r = rises[0];
        frame(0, 2, 5, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("wr5_handshakes", hs, 256);
        chk("wr5_nbytes", rx_size(0) - s, 257);
        chk("wr5_cmd", rx_at(0, s), 8'h25);
        c = 8'(rx_at(0, s));
        if (c[7:3] == 5'b00100)
            for (int i = 0; i < 256; i++) osd_buf[int'(c[2:0]) * 256 + i] = 8'(rx_at(0, s + 1 + i));
        errs = 0;
        for (int i = 0; i < 256; i++) if (osd_buf[1280 + i] !== (8'(i) ^ 8'hA5)) errs++;
        chk("wr5_buffer", errs, 0);
        chk("wr5_latency", lat, exp_lat(4, 256, 0));
        chk("wr5_rises", rises[0] - r, 8 * 257);

        // Back-pressure: 37-clk stall before byte 10, random line and payload
        for (int i = 0; i < 256; i++) pay_mem[i] = 8'($urandom);
        ln = $urandom_range(0, 7);
        s = rx_size(0); r = rises[0];
        frame(0, 2, ln, 10, 37, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("bp_sck_low", ssk, 0);
        chk("bp_stall_len", waits, 37);
        chk("bp_cmd", rx_at(0, s), int'(exp_cmd(2, ln)));
        chk("bp_payload", pay_errs(0, s), 0);
        chk("bp_rises", rises[0] - r, 8 * 257);
        chk("bp_latency", lat, exp_lat(4, 256, 37));
        chk("bp_handshakes", hs, 256);

        // Reset after 100 payload bytes, then a clean disable
        frame(0, 2, 3, -1, 0, 1'b0, 100, lat, hs, viol, ssk, waits);
        s = rx_size(0);
        frame(0, 0, 0, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("dis_nbytes", rx_size(0) - s, 1);
        chk("dis_byte", rx_at(0, s), 8'h40);
        chk("dis_latency", lat, exp_lat(4, 0, 0));

        // CLK_DIV=1 back-to-back: enable, reserved, disable
        s = rx_size(1);
        frame(1, 1, 0, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("d1_en_byte", rx_at(1, s), 8'h41);
        chk("d1_en_latency", lat, exp_lat(1, 0, 0));
        chk("d1_en_ready", viol, 0);
        f = ss_falls[1]; s = rx_size(1);
        frame(1, 3, 0, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("d1_rsvd_done", lat, 0);
        chk("d1_rsvd_no_ss", ss_falls[1] - f, 0);
        chk("d1_rsvd_no_bytes", rx_size(1) - s, 0);
        s = rx_size(1);
        frame(1, 0, 0, -1, 0, 1'b0, -1, lat, hs, viol, ssk, waits);
        chk("d1_dis_byte", rx_at(1, s), 8'h40);
        chk("d1_dis_ready", viol, 0);
        chk("d1_ss_gap_ge2", int'(last_gap[1] >= 2), 1);

        // CLK_DIV=1 write with randomly stalling source
        for (int i = 0; i < 256; i++) pay_mem[i] = 8'($urandom);
        ln = $urandom_range(0, 7);
        s = rx_size(1);
        frame(1, 2, ln, -1, 0, 1'b1, -1, lat, hs, viol, ssk, waits);
        chk("d1_wr_cmd", rx_at(1, s), int'(exp_cmd(2, ln)));
        chk("d1_wr_payload", pay_errs(1, s), 0);
        chk("d1_wr_handshakes", hs, 256);
        chk("d1_wr_latency", lat, exp_lat(1, 256, waits));

        chk("sdi_stable_hi_dut4", sdi_viol[0], 0);
        chk("sdi_stable_hi_dut1", sdi_viol[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
